// File: rtl/branch_unit_pkg.sv
// branch_unit_pkg: shared constants for the branch unit.
//   JMP_*   : JMPX mode codes
//   CC_SEL_*: CC_SELECTX flag select codes
//   OFS_*   : PC_OFFSETX encodings (PC offset mux select)
//   BASE_*  : PC_BASEX encodings (PC base mux select)
package branch_unit_pkg;

  // JMPX modes
  localparam logic [2:0] JMP_ABS_REG  = 3'd0;
  localparam logic [2:0] JMP_ABS_HERE = 3'd1;
  localparam logic [2:0] JMP_IND_REG  = 3'd2;
  localparam logic [2:0] JMP_REL_HERE = 3'd3;
  localparam logic [2:0] JMP_CALL_ABS = 3'd4;
  localparam logic [2:0] JMP_CALL_REL = 3'd5;
  localparam logic [2:0] JMP_RET      = 3'd6;
  localparam logic [2:0] JMP_NONE     = 3'd7;

  // CC_SELECTX flag selects
  localparam logic [1:0] CC_SEL_Z = 2'd0;
  localparam logic [1:0] CC_SEL_C = 2'd1;
  localparam logic [1:0] CC_SEL_P = 2'd2;
  localparam logic [1:0] CC_SEL_S = 2'd3;

  // PC offset mux selects
  localparam logic [1:0] OFS_PLUS2  = 2'd0;
  localparam logic [1:0] OFS_DIN    = 2'd1;
  localparam logic [1:0] OFS_RS_TOP = 2'd2;

  // PC base mux selects
  localparam logic [1:0] BASE_PC_A = 2'd0;
  localparam logic [1:0] BASE_ZERO = 2'd1;

endpackage

// File: rtl/branch_unit_return_stack.sv
// return_stack: circular return-address stack with sticky error flags.
//   clk, rst_n  : clock, async active-low reset
//   push        : write push_data as new top (overwrites oldest when full)
//   pop         : pop request; on an empty stack it only raises unf
//   push_data   : address to push
//   flag_clr    : clear ovf/unf (a same-cycle new error keeps the flag set)
//   top         : top entry, 0 when empty
//   count       : valid entries, saturating 0..RS_DEPTH
//   ovf, unf    : sticky overflow / underflow
module return_stack
  import branch_unit_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int RS_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [ADDR_W-1:0]           push_data,
  input  logic                        flag_clr,
  output logic [ADDR_W-1:0]           top,
  output logic [$clog2(RS_DEPTH):0]   count,
  output logic                        ovf,
  output logic                        unf
);

  localparam int PTR_W = $clog2(RS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is not reset: entries outside count are never visible on top.
  logic [ADDR_W-1:0] mem_q [RS_DEPTH];

  // sp_q is the next write slot; the top entry lives at sp_q-1.
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty, ovf_set, unf_set;

  assign full  = (cnt_q == CNT_W'(RS_DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push) begin
      // Pointer wraps modulo RS_DEPTH; when full the oldest slot is reused.
      sp_d = sp_q + PTR_W'(1);
      if (full) ovf_set = 1'b1;
      else      cnt_d   = cnt_q + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        sp_d  = sp_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    ovf_d = (ovf_q & ~flag_clr) | ovf_set;
    unf_d = (unf_q & ~flag_clr) | unf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[sp_q] <= push_data;
  end

  assign top   = empty ? '0 : mem_q[sp_q - PTR_W'(1)];
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: rtl/branch_unit.sv
// branch_unit: condition evaluation, PC mux select decode and return stack.
//   CLK, RESETN             : clock, async active-low reset
//   CC_ZERO/CARRY/PARITY/SIGN: ALU flags
//   CC_SELECTX/INVERTX/APPLYX: flag select, invert, make-conditional
//   JMPX, BR_EN             : branch mode, execute strobe
//   PC_A                    : current instruction address
//   FLAG_CLR                : clear sticky stack errors
//   PC_OFFSETX, PC_BASEX    : PC offset/base mux selects (combinational)
//   RS_TOP, RS_COUNT        : stack top entry and occupancy
//   RS_OVF, RS_UNF          : sticky stack errors
//   TAKEN                   : registered taken-branch indication
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int RS_DEPTH = 8
) (
  input  logic                        CLK,
  input  logic                        RESETN,
  input  logic                        CC_ZERO,
  input  logic                        CC_CARRY,
  input  logic                        CC_PARITY,
  input  logic                        CC_SIGN,
  input  logic [1:0]                  CC_SELECTX,
  input  logic                        CC_INVERTX,
  input  logic                        CC_APPLYX,
  input  logic [2:0]                  JMPX,
  input  logic                        BR_EN,
  input  logic [ADDR_W-1:0]           PC_A,
  input  logic                        FLAG_CLR,
  output logic [1:0]                  PC_OFFSETX,
  output logic [1:0]                  PC_BASEX,
  output logic [ADDR_W-1:0]           RS_TOP,
  output logic [$clog2(RS_DEPTH):0]   RS_COUNT,
  output logic                        RS_OVF,
  output logic                        RS_UNF,
  output logic                        TAKEN
);

  logic cc, cond, taken, push, pop_req;
  logic taken_q, taken_d;
  logic rs_empty;

  always_comb begin
    case (CC_SELECTX)
      CC_SEL_Z: cc = CC_ZERO;
      CC_SEL_C: cc = CC_CARRY;
      CC_SEL_P: cc = CC_PARITY;
      default:  cc = CC_SIGN;
    endcase
  end

  assign cond     = ~CC_APPLYX | (cc ^ CC_INVERTX);
  assign rs_empty = (RS_COUNT == '0);

  always_comb begin
    PC_OFFSETX = OFS_PLUS2;
    PC_BASEX   = BASE_PC_A;
    taken      = 1'b0;
    push       = 1'b0;
    pop_req    = 1'b0;
    if (BR_EN && cond) begin
      case (JMPX)
        JMP_ABS_REG, JMP_ABS_HERE, JMP_IND_REG: begin
          PC_OFFSETX = OFS_DIN;
          PC_BASEX   = BASE_ZERO;
          taken      = 1'b1;
        end
        JMP_CALL_ABS: begin
          PC_OFFSETX = OFS_DIN;
          PC_BASEX   = BASE_ZERO;
          taken      = 1'b1;
          push       = 1'b1;
        end
        JMP_REL_HERE: begin
          PC_OFFSETX = OFS_DIN;
          taken      = 1'b1;
        end
        JMP_CALL_REL: begin
          PC_OFFSETX = OFS_DIN;
          taken      = 1'b1;
          push       = 1'b1;
        end
        JMP_RET: begin
          // The pop request still goes to the stack when empty so it can
          // flag underflow; the branch itself falls through.
          pop_req = 1'b1;
          if (!rs_empty) begin
            PC_OFFSETX = OFS_RS_TOP;
            PC_BASEX   = BASE_ZERO;
            taken      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign taken_d = taken;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) taken_q <= 1'b0;
    else         taken_q <= taken_d;
  end

  assign TAKEN = taken_q;

  return_stack #(
    .ADDR_W   (ADDR_W),
    .RS_DEPTH (RS_DEPTH)
  ) u_rs (
    .clk       (CLK),
    .rst_n     (RESETN),
    .push      (push),
    .pop       (pop_req),
    .push_data (PC_A + ADDR_W'(2)),
    .flag_clr  (FLAG_CLR),
    .top       (RS_TOP),
    .count     (RS_COUNT),
    .ovf       (RS_OVF),
    .unf       (RS_UNF)
  );

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed scoreboard bench for branch_unit.
module tb_branch_unit;
  import branch_unit_pkg::*;

  localparam int ADDR_W   = 16;
  localparam int RS_DEPTH = 8;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic CC_ZERO = 0, CC_CARRY = 0, CC_PARITY = 0, CC_SIGN = 0;
  logic [1:0] CC_SELECTX = '0;
  logic CC_INVERTX = 0, CC_APPLYX = 0;
  logic [2:0] JMPX = JMP_NONE;
  logic BR_EN = 0;
  logic [ADDR_W-1:0] PC_A = '0;
  logic FLAG_CLR = 0;
  logic [1:0] PC_OFFSETX, PC_BASEX;
  logic [ADDR_W-1:0] RS_TOP;
  logic [$clog2(RS_DEPTH):0] RS_COUNT;
  logic RS_OVF, RS_UNF, TAKEN;

  branch_unit #(.ADDR_W(ADDR_W), .RS_DEPTH(RS_DEPTH)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .CC_ZERO(CC_ZERO), .CC_CARRY(CC_CARRY), .CC_PARITY(CC_PARITY), .CC_SIGN(CC_SIGN),
    .CC_SELECTX(CC_SELECTX), .CC_INVERTX(CC_INVERTX), .CC_APPLYX(CC_APPLYX),
    .JMPX(JMPX), .BR_EN(BR_EN), .PC_A(PC_A), .FLAG_CLR(FLAG_CLR),
    .PC_OFFSETX(PC_OFFSETX), .PC_BASEX(PC_BASEX), .RS_TOP(RS_TOP),
    .RS_COUNT(RS_COUNT), .RS_OVF(RS_OVF), .RS_UNF(RS_UNF), .TAKEN(TAKEN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   miss = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs);
    exp_t e;
    vecs++;
    if (sb.size() == 0) begin
      miss++;
      $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val && tag == e.tag) else begin
        miss++;
        $error("FAIL %s: observed %0h expected %0h (entry %s)", tag, obs, e.val, e.tag);
      end
    end
  endtask

  task automatic drive(input logic br, input logic [2:0] j, input logic [ADDR_W-1:0] pc);
    @(negedge CLK);
    BR_EN = br;
    JMPX  = j;
    PC_A  = pc;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic edge_wait();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    expect_v("rst_cnt", 0); expect_v("rst_top", 0); expect_v("rst_ovf", 0);
    expect_v("rst_unf", 0); expect_v("rst_taken", 0);
    cmp("rst_cnt", 32'(RS_COUNT)); cmp("rst_top", 32'(RS_TOP)); cmp("rst_ovf", 32'(RS_OVF));
    cmp("rst_unf", 32'(RS_UNF)); cmp("rst_taken", 32'(TAKEN));
    @(negedge CLK);
    RESETN = 1'b1;

    // Conditional REL_HERE with Z=1 inverted -> not taken
    CC_SELECTX = CC_SEL_Z; CC_APPLYX = 1; CC_INVERTX = 1; CC_ZERO = 1;
    drive(1, JMP_REL_HERE, 16'h0100);
    expect_v("nt_ofs", OFS_PLUS2); expect_v("nt_base", BASE_PC_A); expect_v("nt_taken", 0);
    settle(); cmp("nt_ofs", 32'(PC_OFFSETX)); cmp("nt_base", 32'(PC_BASEX));
    edge_wait(); cmp("nt_taken", 32'(TAKEN));

    // Same without invert -> taken relative
    drive(1, JMP_REL_HERE, 16'h0100);
    CC_INVERTX = 0;
    expect_v("rel_ofs", OFS_DIN); expect_v("rel_base", BASE_PC_A); expect_v("rel_taken", 1);
    settle(); cmp("rel_ofs", 32'(PC_OFFSETX)); cmp("rel_base", 32'(PC_BASEX));
    edge_wait(); cmp("rel_taken", 32'(TAKEN));

    // Carry-conditional ABS_REG taken
    drive(1, JMP_ABS_REG, 16'h0200);
    CC_SELECTX = CC_SEL_C; CC_CARRY = 1; CC_ZERO = 0;
    expect_v("c_ofs", OFS_DIN); expect_v("c_base", BASE_ZERO);
    settle(); cmp("c_ofs", 32'(PC_OFFSETX)); cmp("c_base", 32'(PC_BASEX));

    // Parity low selected -> IND_REG not taken
    drive(1, JMP_IND_REG, 16'h0200);
    CC_SELECTX = CC_SEL_P; CC_PARITY = 0;
    expect_v("p_ofs", OFS_PLUS2); expect_v("p_taken", 0);
    settle(); cmp("p_ofs", 32'(PC_OFFSETX));
    edge_wait(); cmp("p_taken", 32'(TAKEN));

    // Sign high inverted -> ABS_HERE not taken; not inverted -> taken
    drive(1, JMP_ABS_HERE, 16'h0200);
    CC_SELECTX = CC_SEL_S; CC_SIGN = 1; CC_INVERTX = 1;
    expect_v("s_inv_ofs", OFS_PLUS2);
    settle(); cmp("s_inv_ofs", 32'(PC_OFFSETX));
    CC_INVERTX = 0;
    expect_v("s_ofs", OFS_DIN); expect_v("s_base", BASE_ZERO);
    settle(); cmp("s_ofs", 32'(PC_OFFSETX)); cmp("s_base", 32'(PC_BASEX));
    CC_APPLYX = 0; CC_SIGN = 0; CC_CARRY = 0;

    // BR_EN low and JMPX=NONE give defaults
    drive(0, JMP_ABS_REG, 16'h0300);
    expect_v("nobr_ofs", OFS_PLUS2); expect_v("nobr_taken", 0);
    settle(); cmp("nobr_ofs", 32'(PC_OFFSETX));
    edge_wait(); cmp("nobr_taken", 32'(TAKEN));
    drive(1, JMP_NONE, 16'h0300);
    expect_v("none_ofs", OFS_PLUS2); expect_v("none_base", BASE_PC_A);
    settle(); cmp("none_ofs", 32'(PC_OFFSETX)); cmp("none_base", 32'(PC_BASEX));

    // CALL_ABS at 0x1000 then RET
    drive(1, JMP_CALL_ABS, 16'h1000);
    expect_v("call_ofs", OFS_DIN); expect_v("call_base", BASE_ZERO);
    expect_v("call_cnt", 1); expect_v("call_top", 16'h1002); expect_v("call_taken", 1);
    settle(); cmp("call_ofs", 32'(PC_OFFSETX)); cmp("call_base", 32'(PC_BASEX));
    edge_wait(); cmp("call_cnt", 32'(RS_COUNT)); cmp("call_top", 32'(RS_TOP)); cmp("call_taken", 32'(TAKEN));
    drive(1, JMP_RET, 16'h4000);
    expect_v("ret_ofs", OFS_RS_TOP); expect_v("ret_base", BASE_ZERO);
    expect_v("ret_cnt", 0); expect_v("ret_top", 0); expect_v("ret_taken", 1);
    settle(); cmp("ret_ofs", 32'(PC_OFFSETX)); cmp("ret_base", 32'(PC_BASEX));
    edge_wait(); cmp("ret_cnt", 32'(RS_COUNT)); cmp("ret_top", 32'(RS_TOP)); cmp("ret_taken", 32'(TAKEN));

    // Not-taken CALL leaves the stack alone
    drive(1, JMP_CALL_ABS, 16'h1000);
    CC_APPLYX = 1; CC_SELECTX = CC_SEL_Z; CC_ZERO = 0;
    expect_v("ntcall_cnt", 0); expect_v("ntcall_taken", 0);
    edge_wait(); cmp("ntcall_cnt", 32'(RS_COUNT)); cmp("ntcall_taken", 32'(TAKEN));
    CC_APPLYX = 0;

    // RET on empty -> underflow, then FLAG_CLR racing a new underflow
    drive(1, JMP_RET, 16'h0000);
    expect_v("uret_ofs", OFS_PLUS2); expect_v("uret_base", BASE_PC_A);
    expect_v("uret_taken", 0); expect_v("uret_unf", 1);
    settle(); cmp("uret_ofs", 32'(PC_OFFSETX)); cmp("uret_base", 32'(PC_BASEX));
    edge_wait(); cmp("uret_taken", 32'(TAKEN)); cmp("uret_unf", 32'(RS_UNF));
    drive(1, JMP_RET, 16'h0000);
    FLAG_CLR = 1;
    expect_v("clr_race_unf", 1);
    edge_wait(); cmp("clr_race_unf", 32'(RS_UNF));
    drive(0, JMP_NONE, 16'h0000);
    expect_v("clr_unf", 0);
    edge_wait(); cmp("clr_unf", 32'(RS_UNF));
    FLAG_CLR = 0;

    // CALL_REL at 0xFFFE wraps to 0x0000
    drive(1, JMP_CALL_REL, 16'hFFFE);
    expect_v("wrap_ofs", OFS_DIN); expect_v("wrap_base", BASE_PC_A);
    expect_v("wrap_cnt", 1); expect_v("wrap_top", 16'h0000);
    settle(); cmp("wrap_ofs", 32'(PC_OFFSETX)); cmp("wrap_base", 32'(PC_BASEX));
    edge_wait(); cmp("wrap_cnt", 32'(RS_COUNT)); cmp("wrap_top", 32'(RS_TOP));
    drive(1, JMP_RET, 16'h0000);
    expect_v("wrap_drain", 0);
    edge_wait(); cmp("wrap_drain", 32'(RS_COUNT));

    // Nine CALLs into an eight-deep stack
    for (int i = 0; i < 9; i++) begin
      drive(1, JMP_CALL_ABS, ADDR_W'(2 * i));
      expect_v("ovf_cnt", (i + 1 > RS_DEPTH) ? RS_DEPTH : i + 1);
      expect_v("ovf_top", 2 * i + 2);
      edge_wait(); cmp("ovf_cnt", 32'(RS_COUNT)); cmp("ovf_top", 32'(RS_TOP));
    end
    expect_v("ovf_flag", 1);
    cmp("ovf_flag", 32'(RS_OVF));
    for (int k = 0; k < RS_DEPTH; k++) begin
      drive(1, JMP_RET, 16'h0000);
      expect_v("drain_top", 18 - 2 * k); expect_v("drain_ofs", OFS_RS_TOP);
      expect_v("drain_cnt", RS_DEPTH - 1 - k);
      settle(); cmp("drain_top", 32'(RS_TOP)); cmp("drain_ofs", 32'(PC_OFFSETX));
      edge_wait(); cmp("drain_cnt", 32'(RS_COUNT));
    end
    drive(1, JMP_RET, 16'h0000);
    expect_v("lost_top", 0); expect_v("lost_ofs", OFS_PLUS2); expect_v("lost_unf", 1);
    settle(); cmp("lost_top", 32'(RS_TOP)); cmp("lost_ofs", 32'(PC_OFFSETX));
    edge_wait(); cmp("lost_unf", 32'(RS_UNF));

    // Reset asserted during a taken CALL
    drive(1, JMP_CALL_ABS, 16'h2000);
    expect_v("pre_cnt", 1); expect_v("pre_taken", 1);
    edge_wait(); cmp("pre_cnt", 32'(RS_COUNT)); cmp("pre_taken", 32'(TAKEN));
    drive(1, JMP_CALL_ABS, 16'h2100);
    #2 RESETN = 1'b0;
    #1;
    expect_v("mid_cnt", 0); expect_v("mid_taken", 0); expect_v("mid_ovf", 0);
    expect_v("mid_unf", 0); expect_v("mid_top", 0);
    cmp("mid_cnt", 32'(RS_COUNT)); cmp("mid_taken", 32'(TAKEN)); cmp("mid_ovf", 32'(RS_OVF));
    cmp("mid_unf", 32'(RS_UNF)); cmp("mid_top", 32'(RS_TOP));
    edge_wait();
    drive(0, JMP_NONE, 16'h0000);
    RESETN = 1'b1;
    expect_v("post_cnt", 0); expect_v("post_taken", 0);
    edge_wait(); cmp("post_cnt", 32'(RS_COUNT)); cmp("post_taken", 32'(TAKEN));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, width of PC, DIN and return-stack entries.
REQ-002 Parameter RS_DEPTH, default 8, return-stack entries; power of two, 2..64.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESETN  in  1  asynchronous, active-low reset.
REQ-005 CC_ZERO, CC_CARRY, CC_PARITY, CC_SIGN  in  1 each  ALU condition flags.
REQ-006 CC_SELECTX  in  2  flag select: Z=0, C=1, P=2, S=3.
REQ-007 CC_INVERTX  in  1  invert selected flag; CC_APPLYX  in  1  make branch conditional.
REQ-008 JMPX  in  3  mode: 0 ABS_REG, 1 ABS_HERE, 2 IND_REG, 3 REL_HERE, 4 CALL_ABS, 5 CALL_REL, 6 RET, 7 NONE.
REQ-009 BR_EN  in  1  instruction-execute strobe; mode and stack act only when high.
REQ-010 PC_A  in  ADDR_W  address of the current instruction.
REQ-011 FLAG_CLR  in  1  clears sticky stack error flags.
REQ-012 PC_OFFSETX  out  2  offset select: 0 = +2, 1 = DIN, 2 = RS_TOP.
REQ-013 PC_BASEX  out  2  base select: 0 = PC_A, 1 = zero.
REQ-014 RS_TOP  out  ADDR_W  top-of-stack entry; 0 when empty.
REQ-015 RS_COUNT  out  $clog2(RS_DEPTH)+1  current number of valid entries.
REQ-016 RS_OVF, RS_UNF  out  1 each  sticky overflow / underflow flags.
REQ-017 TAKEN  out  1  registered: high one cycle after a taken branch.

Function
REQ-018 CC = flag chosen by CC_SELECTX; COND = ~CC_APPLYX | (CC ^ CC_INVERTX); combinational, zero latency.
REQ-019 Default outputs (BR_EN low, JMPX=7, or COND low): PC_OFFSETX=0, PC_BASEX=0.
REQ-020 Taken modes 0, 1, 2, 4: PC_OFFSETX=1, PC_BASEX=1; modes 3, 5: PC_OFFSETX=1, PC_BASEX=0.
REQ-021 Taken mode 6 with RS_COUNT>0: PC_OFFSETX=2, PC_BASEX=1.
REQ-022 Mode 6 with RS_COUNT=0: branch not taken (default outputs), no pop, RS_UNF set next edge.
REQ-023 Taken CALL (modes 4, 5) pushes (PC_A+2) mod 2^ADDR_W on the next edge; RS_TOP reflects it the following cycle.
REQ-024 Taken RET pops on the next edge; RS_TOP updates to the next entry, or 0 if now empty.
REQ-025 Push when RS_COUNT=RS_DEPTH: stack is circular, oldest entry overwritten, RS_COUNT stays RS_DEPTH, RS_OVF set.
REQ-026 Push and pop are mutually exclusive per cycle by construction of JMPX; no other stack operation exists.
REQ-027 Not-taken CALL/RET (COND low): no stack change, no flag change.
REQ-028 TAKEN = registered (BR_EN & taken); RET on empty stack counts as not taken.
REQ-029 FLAG_CLR clears RS_OVF and RS_UNF on the next edge; a new error in the same cycle wins (flag remains set).
REQ-030 Stack pointer arithmetic is modulo RS_DEPTH; RS_COUNT is saturating in 0..RS_DEPTH.

Reset
REQ-031 RESETN low asynchronously clears RS_COUNT, pointer, RS_OVF, RS_UNF and TAKEN; RS_TOP reads 0.
REQ-032 Stack storage contents need no reset; entries are unreadable while RS_COUNT excludes them.
REQ-033 Reset asserted mid-CALL or mid-RET discards the pending push/pop; the first edge after release performs no stack operation unless BR_EN is high.

Structure
REQ-034 JMPX mode codes, CC_SELECTX codes and PC_OFFSETX/PC_BASEX encodings live in the shared constants file alongside the existing PC select codes.
REQ-035 The return stack is a sub-module, return_stack (parameters ADDR_W, RS_DEPTH; push, pop, top, count, ovf, unf).
REQ-036 Condition evaluation and select decode remain combinational in branch_unit.

Verification
REQ-037 CC_SELECTX=0, CC_APPLYX=1, CC_INVERTX=1, CC_ZERO=1, JMPX=3, BR_EN=1 -> PC_OFFSETX=0, PC_BASEX=0, TAKEN=0 next cycle.
REQ-038 CALL_ABS at PC_A=0x1000, then RET -> RS_TOP=0x1002 after the push; RET gives PC_OFFSETX=2, PC_BASEX=1; RS_COUNT returns 1->0.
REQ-039 RS_DEPTH=8: nine CALLs at PC_A=0,2,..,16 -> RS_COUNT=8, RS_OVF=1, RS_TOP=18; eight RETs drain to 4, entry 2 is lost.
REQ-040 RET on empty -> default selects, TAKEN=0, RS_UNF=1; FLAG_CLR with a simultaneous empty RET -> RS_UNF stays 1.
REQ-041 PC_A=0xFFFE, CALL_REL, ADDR_W=16 -> pushed value 0x0000.
REQ-042 Assert RESETN low during a taken CALL -> RS_COUNT=0, TAKEN=0 immediately; no push after release.
